// File: rtl/alarm_mode_pkg.sv
// Shared mode codes, state encoding and prescaler helpers for the alarm mode controller.
package alarm_mode_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_WELCOME = 2'b01;
    localparam logic [1:0] MODE_ALARM   = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_WELCOME = 2'd1,
        ST_ARMED   = 2'd2,
        ST_ALARM   = 2'd3
    } state_e;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned TICK_DIV   = DEF_CLK_HZ / 1000;

    // Cycles per 1 ms tick for a given clock frequency.
    function automatic int unsigned tick_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // LED/buzzer mode code presented while in a given state.
    function automatic logic [1:0] mode_of(input state_e st);
        logic [1:0] m;
        case (st)
            ST_WELCOME: m = MODE_WELCOME;
            ST_ALARM:   m = MODE_ALARM;
            default:    m = MODE_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alarm_mode_ctrl_key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one asynchronous input.
// act_p pulses for one cycle when the debounced level leaves its rest (reset) level.
// Events are only emitted once the input has been seen at rest on a tick, so an
// input held active through reset never produces an event.
module key_debounce
    import alarm_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter logic        RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic act_p
);

    localparam int unsigned CNT_W    = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             valid_q, valid_d;
    logic             act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchronise, count consecutive disagreeing ticks, flag activation edge.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        valid_d = valid_q | (tick & (sync2_q == RESET_LEVEL));
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        act_d = valid_q & (level_q == RESET_LEVEL) & (level_d != RESET_LEVEL);
    end

    // State registers; levels reset to the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            valid_q <= 1'b0;
            act_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            valid_q <= valid_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign act_p = act_q;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Arm/alarm controller producing the LED/buzzer mode code, armed status and alarm IRQ.
// Optional build macro: ALARM_AUTO_CLEAR_EN (ALARM returns to ARMED after a quiet timeout).
module alarm_mode_ctrl
    import alarm_mode_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 50_000_000,
    parameter int unsigned DEBOUNCE_MS      = 20,
    parameter int unsigned WELCOME_MS       = 3000,
    parameter int unsigned ALARM_TIMEOUT_MS = 30000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_arm_n,
    input  logic       key_disarm_n,
    input  logic       sensor_in,
    output logic [1:0] mode,
    output logic       armed,
    output logic       alarm_irq,
    output logic [1:0] state_dbg
);

    localparam int unsigned DIV    = tick_div(CLK_HZ);
    localparam int unsigned PRE_W  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned MS_MAX = (WELCOME_MS > ALARM_TIMEOUT_MS) ? WELCOME_MS : ALARM_TIMEOUT_MS;
    localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

    logic             arm_p, disarm_p, sens_p;
    logic             arm_lvl, disarm_lvl, sens_lvl;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d, ms_inc;
    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic             armed_q, irq_q, irq_d;

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .RESET_LEVEL(1'b1)) u_db_arm (
        .clk(clk), .rst(rst), .tick(tick_q), .din(key_arm_n), .level(arm_lvl), .act_p(arm_p)
    );
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .RESET_LEVEL(1'b1)) u_db_disarm (
        .clk(clk), .rst(rst), .tick(tick_q), .din(key_disarm_n), .level(disarm_lvl), .act_p(disarm_p)
    );
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .RESET_LEVEL(1'b0)) u_db_sens (
        .clk(clk), .rst(rst), .tick(tick_q), .din(sensor_in), .level(sens_lvl), .act_p(sens_p)
    );

    // Debounced levels the FSM does not consume.
`ifdef ALARM_AUTO_CLEAR_EN
    logic unused_lvls;
    assign unused_lvls = arm_lvl ^ disarm_lvl;
`else
    logic unused_lvls;
    assign unused_lvls = arm_lvl ^ disarm_lvl ^ sens_lvl;
`endif

    // Free-running 1 ms prescaler; tick is a registered one-cycle pulse at wrap.
    always_comb begin
        tick_d = (pre_q == PRE_W'(DIV - 1));
        pre_d  = tick_d ? '0 : pre_q + PRE_W'(1);
    end

    // Saturating ms counter increment.
    assign ms_inc = (ms_cnt_q == MS_W'(MS_MAX)) ? ms_cnt_q : ms_cnt_q + MS_W'(1);

    // Next-state, timer and IRQ logic; disarm overrides every other event.
    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        irq_d    = 1'b0;
        if (tick_q) ms_cnt_d = ms_inc;
        case (state_q)
            ST_OFF: begin
                if (arm_p) begin
                    state_d  = ST_WELCOME;
                    ms_cnt_d = '0;
                end
            end
            ST_WELCOME: begin
                if (tick_q && (ms_inc == MS_W'(WELCOME_MS))) begin
                    state_d  = ST_ARMED;
                    ms_cnt_d = '0;
                end
            end
            ST_ARMED: begin
                if (sens_p) begin
                    state_d  = ST_ALARM;
                    ms_cnt_d = '0;
                    irq_d    = 1'b1;
                end
            end
            ST_ALARM: begin
`ifdef ALARM_AUTO_CLEAR_EN
                if (tick_q && (ms_inc == MS_W'(ALARM_TIMEOUT_MS))) begin
                    ms_cnt_d = '0;
                    if (!sens_lvl) state_d = ST_ARMED;
                end
`endif
            end
            default: state_d = ST_OFF;
        endcase
        if (disarm_p) begin
            state_d  = ST_OFF;
            ms_cnt_d = '0;
            irq_d    = 1'b0;
        end
    end

    // State, timer and registered output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q    <= '0;
            tick_q   <= 1'b0;
            ms_cnt_q <= '0;
            state_q  <= ST_OFF;
            mode_q   <= MODE_OFF;
            armed_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            ms_cnt_q <= ms_cnt_d;
            state_q  <= state_d;
            mode_q   <= mode_of(state_d);
            armed_q  <= (state_d != ST_OFF);
            irq_q    <= irq_d;
        end
    end

    assign mode      = mode_q;
    assign armed     = armed_q;
    assign alarm_irq = irq_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Directed bench for alarm_mode_ctrl at 10 cycles per ms.
module tb_alarm_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       key_arm_n;
    logic       key_disarm_n;
    logic       sensor_in;
    logic [1:0] mode;
    logic       armed;
    logic       alarm_irq;
    logic [1:0] state_dbg;

    int n_cmp   = 0;
    int n_err   = 0;
    int irq_cnt = 0;
    int exp_irq = 0;

    alarm_mode_ctrl #(
        .CLK_HZ(10_000), .DEBOUNCE_MS(2), .WELCOME_MS(5), .ALARM_TIMEOUT_MS(4)
    ) dut (
        .clk(clk), .rst(rst), .key_arm_n(key_arm_n), .key_disarm_n(key_disarm_n),
        .sensor_in(sensor_in), .mode(mode), .armed(armed), .alarm_irq(alarm_irq),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with the alarm IRQ high.
    always @(negedge clk) if (alarm_irq) irq_cnt <= irq_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mode(input string tag, input logic [1:0] exp, input int budget);
        int n = 0;
        while (mode !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(mode), 32'(exp));
    endtask

    initial begin
        rst = 1'b0; key_arm_n = 1'b0; key_disarm_n = 1'b1; sensor_in = 1'b0;

        // 1: reset with arm key held
        cyc(3);
        check_eq("rst_mode",  32'(mode), 32'h0);
        check_eq("rst_armed", 32'(armed), 32'h0);
        check_eq("rst_irq",   32'(alarm_irq), 32'h0);
        check_eq("rst_state", 32'(state_dbg), 32'h0);
        rst = 1'b1;
        cyc(50);
        check_eq("held_no_arm_state", 32'(state_dbg), 32'h0);
        check_eq("held_no_arm_mode",  32'(mode), 32'h0);
        key_arm_n = 1'b1;
        cyc(40);
        check_eq("release_no_arm", 32'(state_dbg), 32'h0);

        // 3a: bounce shorter than debounce window
        key_arm_n = 1'b0; cyc(8); key_arm_n = 1'b1;
        cyc(50);
        check_eq("bounce_state", 32'(state_dbg), 32'h0);
        check_eq("bounce_armed", 32'(armed), 32'h0);

        // 2 + 3b: arm, sensor during WELCOME ignored, then ARMED
        key_arm_n = 1'b0;
        wait_mode("arm_welcome", 2'b01, 40);
        sensor_in = 1'b1;
        check_eq("welcome_armed", 32'(armed), 32'h1);
        check_eq("welcome_state", 32'(state_dbg), 32'h1);
        key_arm_n = 1'b1;
        cyc(30);
        check_eq("welcome_sens_ignored", 32'(mode), 32'h1);
        cyc(25);
        check_eq("armed_mode",  32'(mode), 32'h0);
        check_eq("armed_armed", 32'(armed), 32'h1);
        check_eq("armed_state", 32'(state_dbg), 32'h2);
        check_eq("armed_no_irq", 32'(irq_cnt), 32'd0);

        // 4: intrusion in ARMED
        sensor_in = 1'b0; cyc(40);
        check_eq("sens_low_armed", 32'(state_dbg), 32'h2);
        sensor_in = 1'b1;
        wait_mode("alarm_mode", 2'b11, 40);
        exp_irq = 1;
        cyc(5);
        check_eq("alarm_state", 32'(state_dbg), 32'h3);
        check_eq("irq_one_cycle", 32'(irq_cnt), 32'(exp_irq));
        key_arm_n = 1'b0; cyc(30); key_arm_n = 1'b1; cyc(30);
        check_eq("alarm_arm_ignored", 32'(mode), 32'h3);
        check_eq("alarm_armed", 32'(armed), 32'h1);
        sensor_in = 1'b0;
        cyc(80);
`ifdef ALARM_AUTO_CLEAR_EN
        check_eq("autoclr_mode",  32'(mode), 32'h0);
        check_eq("autoclr_state", 32'(state_dbg), 32'h2);
        check_eq("autoclr_no_irq", 32'(irq_cnt), 32'(exp_irq));
        sensor_in = 1'b1;
        wait_mode("realarm_mode", 2'b11, 40);
        exp_irq = 2;
`else
        check_eq("alarm_holds", 32'(mode), 32'h3);
        check_eq("alarm_holds_state", 32'(state_dbg), 32'h3);
`endif

        // 5: disarm simultaneous with arm in ALARM, then in OFF
        key_arm_n = 1'b0; key_disarm_n = 1'b0;
        cyc(30);
        check_eq("disarm_mode",  32'(mode), 32'h0);
        check_eq("disarm_armed", 32'(armed), 32'h0);
        check_eq("disarm_state", 32'(state_dbg), 32'h0);
        check_eq("disarm_irq_total", 32'(irq_cnt), 32'(exp_irq));
        key_arm_n = 1'b1; key_disarm_n = 1'b1; sensor_in = 1'b0;
        cyc(40);
        key_arm_n = 1'b0; key_disarm_n = 1'b0;
        cyc(30);
        check_eq("off_disarm_prio", 32'(state_dbg), 32'h0);
        key_arm_n = 1'b1; key_disarm_n = 1'b1;
        cyc(40);

        // 6: async reset in the middle of ALARM
        key_arm_n = 1'b0;
        wait_mode("rearm_welcome", 2'b01, 40);
        key_arm_n = 1'b1;
        cyc(60);
        check_eq("rearm_armed", 32'(state_dbg), 32'h2);
        sensor_in = 1'b1;
        wait_mode("alarm2_mode", 2'b11, 40);
        cyc(3);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_mode",  32'(mode), 32'h0);
        check_eq("async_rst_armed", 32'(armed), 32'h0);
        check_eq("async_rst_state", 32'(state_dbg), 32'h0);
        cyc(3);
        rst = 1'b1;
        cyc(50);
        check_eq("post_rst_sens_held", 32'(state_dbg), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
